// File: rtl/router_synchronizer.sv
// Control glue between the router FSM and its three output FIFOs: destination address latch,
// write-enable decode, full-flag mux, valid generation and per-port read-timeout soft resets.
module router_synchronizer (
  input  logic       detect_addr,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       clk,
  input  logic       resetn,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic [2:0] write_enb,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2,
  output logic       fifo_full
);

  // Counter value on the 30th consecutive stalled edge.
  localparam logic [4:0] CntLast = 5'd29;

  logic [1:0] addr_q;
  logic [2:0] vld;
  logic [2:0] rd;
  logic [2:0] soft_q;
  logic [4:0] cnt_q [3];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q <= 2'b00;
    end else if (detect_addr) begin
      addr_q <= data_in;
    end
  end

  // Address 11 is a null destination: nothing written, never reported full.
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (addr_q)
      2'b00: begin
        write_enb = {2'b00, write_enb_reg};
        fifo_full = full_0;
      end
      2'b01: begin
        write_enb = {1'b0, write_enb_reg, 1'b0};
        fifo_full = full_1;
      end
      2'b10: begin
        write_enb = {write_enb_reg, 2'b00};
        fifo_full = full_2;
      end
      default: begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

  assign vld = ~{empty_2, empty_1, empty_0};
  assign rd  = {read_enb_2, read_enb_1, read_enb_0};

  assign vld_out_0 = vld[0];
  assign vld_out_1 = vld[1];
  assign vld_out_2 = vld[2];

  always_ff @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (!resetn) begin
        cnt_q[n]  <= 5'd0;
        soft_q[n] <= 1'b0;
      end else if (vld[n] && !rd[n]) begin
        if (cnt_q[n] == CntLast) begin
          cnt_q[n]  <= 5'd0;
          soft_q[n] <= 1'b1;
        end else begin
          cnt_q[n]  <= cnt_q[n] + 5'd1;
          soft_q[n] <= 1'b0;
        end
      end else begin
        cnt_q[n]  <= 5'd0;
        soft_q[n] <= 1'b0;
      end
    end
  end

  assign soft_reset_0 = soft_q[0];
  assign soft_reset_1 = soft_q[1];
  assign soft_reset_2 = soft_q[2];

endmodule

// File: tb/tb_router_synchronizer.sv
// Self-checking bench for router_synchronizer: vector table, directed timeout sequences and
// randomized traffic against a stall-run-length reference model.
module tb_router_synchronizer;

  logic       clk = 1'b0;
  logic       detect_addr, write_enb_reg, resetn;
  logic [1:0] data_in;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [2:0] write_enb;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       fifo_full;

  always #5 clk = ~clk;

  router_synchronizer dut (
    .detect_addr  (detect_addr),
    .data_in      (data_in),
    .write_enb_reg(write_enb_reg),
    .clk          (clk),
    .resetn       (resetn),
    .read_enb_0   (read_enb_0),
    .read_enb_1   (read_enb_1),
    .read_enb_2   (read_enb_2),
    .empty_0      (empty_0),
    .empty_1      (empty_1),
    .empty_2      (empty_2),
    .full_0       (full_0),
    .full_1       (full_1),
    .full_2       (full_2),
    .vld_out_0    (vld_out_0),
    .vld_out_1    (vld_out_1),
    .vld_out_2    (vld_out_2),
    .write_enb    (write_enb),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2),
    .fifo_full    (fifo_full)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: count stalled edges since the last restart or pulse; pulse on the 30th.
  int         run [3] = '{0, 0, 0};
  logic [1:0] addr_m   = 2'b00;
  logic [2:0] exp_soft = 3'b000;
  logic [2:0] stall;

  always @(posedge clk) begin
    stall = ~{empty_2, empty_1, empty_0} & ~{read_enb_2, read_enb_1, read_enb_0};
    if (!resetn) begin
      addr_m   = 2'b00;
      exp_soft = 3'b000;
      for (int i = 0; i < 3; i++) run[i] = 0;
    end else begin
      if (detect_addr) addr_m = data_in;
      for (int i = 0; i < 3; i++) begin
        exp_soft[i] = 1'b0;
        if (stall[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == 30) begin
            exp_soft[i] = 1'b1;
            run[i]      = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic [2:0] fulls;
    logic [2:0] exp_we;
    logic       exp_ff;
    fulls  = {full_2, full_1, full_0};
    exp_we = (write_enb_reg && addr_m != 2'b11) ? (3'b001 << addr_m) : 3'b000;
    exp_ff = (addr_m == 2'b11) ? 1'b0 : fulls[addr_m];
    cmp("vld_out", {vld_out_2, vld_out_1, vld_out_0}, ~{empty_2, empty_1, empty_0});
    cmp("write_enb", write_enb, exp_we);
    cmp("fifo_full", {2'b00, fifo_full}, {2'b00, exp_ff});
    cmp("soft_reset", {soft_reset_2, soft_reset_1, soft_reset_0}, exp_soft);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic quiet();
    detect_addr = 1'b0; data_in = 2'b00; write_enb_reg = 1'b0;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    {empty_2, empty_1, empty_0} = 3'b111;
    {full_2, full_1, full_0} = 3'b000;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [1:0] data;
    logic       wreg;
    logic [2:0] full;
    logic [2:0] we;
    logic       ff;
  } vec_t;

  vec_t tbl [8];
  int   hits;

  initial begin
    tbl[0] = '{2'b00, 1'b1, 3'b001, 3'b001, 1'b1};
    tbl[1] = '{2'b01, 1'b1, 3'b010, 3'b010, 1'b1};
    tbl[2] = '{2'b10, 1'b1, 3'b100, 3'b100, 1'b1};
    tbl[3] = '{2'b11, 1'b1, 3'b111, 3'b000, 1'b0};
    tbl[4] = '{2'b10, 1'b1, 3'b011, 3'b100, 1'b0};
    tbl[5] = '{2'b01, 1'b0, 3'b010, 3'b000, 1'b1};
    tbl[6] = '{2'b00, 1'b0, 3'b110, 3'b000, 1'b0};
    tbl[7] = '{2'b10, 1'b1, 3'b000, 3'b100, 1'b0};

    quiet();
    resetn = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state: addr 00 selects FIFO 0.
    write_enb_reg = 1'b1; full_0 = 1'b1;
    #1;
    cmp("reset_write_enb", write_enb, 3'b001);
    cmp("reset_fifo_full", {2'b00, fifo_full}, 3'b001);
    cmp("reset_soft", {soft_reset_2, soft_reset_1, soft_reset_0}, 3'b000);
    @(negedge clk);
    quiet();

    // Vector table: capture address, then decode.
    for (int i = 0; i < 8; i++) begin
      detect_addr = 1'b1; data_in = tbl[i].data;
      step();
      detect_addr = 1'b0; write_enb_reg = tbl[i].wreg;
      {full_2, full_1, full_0} = tbl[i].full;
      #1;
      cmp("tbl_write_enb", write_enb, tbl[i].we);
      cmp("tbl_fifo_full", {2'b00, fifo_full}, {2'b00, tbl[i].ff});
      @(negedge clk);
      quiet();
    end

    // Address 10, ports 0/1 drained continuously, port 2 empty: no timeouts.
    do_reset();
    detect_addr = 1'b1; data_in = 2'b10;
    step();
    detect_addr = 1'b0; write_enb_reg = 1'b1;
    read_enb_0 = 1'b1; read_enb_1 = 1'b1; empty_0 = 1'b0; empty_1 = 1'b0;
    #1;
    cmp("seq1_write_enb", write_enb, 3'b100);
    cmp("seq1_ff_lo", {2'b00, fifo_full}, 3'b000);
    full_2 = 1'b1;
    #1;
    cmp("seq1_ff_hi", {2'b00, fifo_full}, 3'b001);
    cmp("seq1_vld", {vld_out_2, vld_out_1, vld_out_0}, 3'b011);
    hits = 0;
    for (int e = 1; e <= 40; e++) begin
      step();
      hits += int'(soft_reset_0) + int'(soft_reset_1) + int'(soft_reset_2);
    end
    cmp("seq1_no_soft", hits[2:0], 3'b000);
    @(negedge clk);
    quiet();

    // Continuous stall on port 1: pulses after edges 30 and 60.
    do_reset();
    empty_1 = 1'b0;
    for (int e = 1; e <= 65; e++) begin
      step();
      cmp("stall_soft", {soft_reset_2, soft_reset_1, soft_reset_0},
          {1'b0, (e == 30 || e == 60), 1'b0});
    end
    quiet();

    // Read at edge 20 restarts the count: next pulse after edge 50.
    do_reset();
    empty_1 = 1'b0;
    for (int e = 1; e <= 55; e++) begin
      read_enb_1 = (e == 20);
      step();
      cmp("restart_soft1", {2'b00, soft_reset_1}, {2'b00, (e == 50)});
    end
    quiet();

    // Reset mid-count: count starts over from reset release.
    do_reset();
    detect_addr = 1'b1; data_in = 2'b01;
    step();
    detect_addr = 1'b0;
    empty_1 = 1'b0;
    for (int e = 1; e <= 15; e++) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    write_enb_reg = 1'b1;
    #1;
    cmp("midreset_addr", write_enb, 3'b001);
    write_enb_reg = 1'b0;
    for (int e = 1; e <= 35; e++) begin
      step();
      cmp("midreset_soft1", {2'b00, soft_reset_1}, {2'b00, (e == 30)});
    end
    quiet();

    // Staggered stalls on all ports: independent schedules.
    do_reset();
    empty_0 = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      step();
      if (e == 5)  empty_1 = 1'b0;
      if (e == 10) empty_2 = 1'b0;
      cmp("stagger_soft", {soft_reset_2, soft_reset_1, soft_reset_0},
          {(e == 40), (e == 35), (e == 30)});
    end
    quiet();

    // Randomized traffic, checked every cycle against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      resetn        = ($urandom_range(0, 299) != 0);
      detect_addr   = ($urandom_range(0, 7) == 0);
      data_in       = 2'($urandom_range(0, 3));
      write_enb_reg = 1'($urandom_range(0, 1));
      {full_2, full_1, full_0} = 3'($urandom_range(0, 7));
      empty_0 = ($urandom_range(0, 19) == 0);
      empty_1 = ($urandom_range(0, 19) == 0);
      empty_2 = ($urandom_range(0, 19) == 0);
      read_enb_0 = ($urandom_range(0, 39) == 0);
      read_enb_1 = ($urandom_range(0, 39) == 0);
      read_enb_2 = ($urandom_range(0, 39) == 0);
      #1;
      check_outputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
